mfcc_mul_arbiter: RTL and testbench

MFCC_MUL_ARBITER -- requirements
Module: mfcc_mul_arbiter

---
 rtl/mfcc_mul_arbiter_pkg.sv | 17 +
 rtl/mfcc_mul_arbiter_mul.sv | 32 +++
 rtl/mfcc_mul_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mfcc_mul_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mfcc_mul_arbiter_pkg.sv
// Shared constants for the MFCC multiplier arbiter: FSM encoding, multiplier
// latency and the requester tag that travels alongside each product.
package mfcc_mul_arbiter_pkg;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StArb    = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned TAG_W   = 3;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } pipe_t;

endpackage

// File: rtl/mfcc_mul_arbiter_mul.sv
// Three-stage signed 16x16 multiplier: operand register, product register,
// output register. Synchronous reset, clock enable on every stage.
module mul16x16_signed (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ce_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o
);

  logic signed [15:0] a_q, b_q;
  logic signed [31:0] prod_q, p_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      p_q    <= '0;
    end else if (ce_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      // Sign-extend before multiplying so the full 32-bit product is kept.
      prod_q <= 32'(a_q) * 32'(b_q);
      p_q    <= prod_q;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/mfcc_mul_arbiter.sv
// Round-robin arbiter with burst locking in front of a shared pipelined
// signed multiplier; results return in order, tagged with the requester.
module mfcc_mul_arbiter
  import mfcc_mul_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned LOCK_MAX = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    lock_i,
  input  logic [16*NREQ-1:0] op_a_i,
  input  logic [16*NREQ-1:0] op_b_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [31:0]        p_o,
  output logic [NREQ-1:0]    p_valid_o,
  output logic               busy_o,
  output logic               lock_err_o
);

  localparam int unsigned PtrW = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

  logic [1:0]      state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] skip_q, skip_d;
  logic            lock_err_q, lock_err_d;
  logic [15:0]     opa_q, opa_d, opb_q, opb_d;
  pipe_t [MUL_LAT:0] pipe_q, pipe_d;
  logic [31:0]     p_q, p_d;
  logic [NREQ-1:0] p_valid_q, p_valid_d;

  logic [NREQ-1:0] gnt, eligible;
  logic [PtrW-1:0] gnt_idx, scan_idx;
  logic            found, xfer;
  logic [31:0]     mul_p;

  function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] i);
    return (i == PtrW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    scan_idx = ptr_q;
    eligible = req_i & ~skip_q;
    if (state_q == StArb) begin
      for (int off = 0; off < int'(NREQ); off++) begin
        if (!found && eligible[scan_idx]) begin
          found         = 1'b1;
          gnt[scan_idx] = 1'b1;
          gnt_idx       = scan_idx;
        end
        scan_idx = wrap_inc(scan_idx);
      end
    end else if (state_q == StLocked) begin
      // Idle cycles of the owner are not handed to anyone else.
      if (req_i[owner_q]) begin
        gnt[owner_q] = 1'b1;
        gnt_idx      = owner_q;
      end
    end
  end

  assign xfer  = |gnt;
  assign gnt_o = gnt;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    skip_d     = skip_q;
    lock_err_d = lock_err_q;
    case (state_q)
      StIdle: begin
        if (|req_i) state_d = StArb;
      end
      StArb: begin
        skip_d = '0;
        if (xfer) begin
          ptr_d = wrap_inc(gnt_idx);
          if (lock_i[gnt_idx]) begin
            state_d = StLocked;
            owner_d = gnt_idx;
            cnt_d   = CntW'(1);
          end
        end else if (!(|req_i)) begin
          state_d = StIdle;
        end
      end
      StLocked: begin
        if (xfer) begin
          ptr_d = wrap_inc(owner_q);
          cnt_d = cnt_q + 1'b1;
        end
        if (!req_i[owner_q] || !lock_i[owner_q]) begin
          state_d = StArb;
        end else if (cnt_q == CntW'(LOCK_MAX - 1)) begin
          // Watchdog release: owner sits out the next arbitration round.
          state_d         = StArb;
          lock_err_d      = 1'b1;
          skip_d          = '0;
          skip_d[owner_q] = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    opa_d = opa_q;
    opb_d = opb_q;
    if (xfer) begin
      opa_d = op_a_i[{gnt_idx, 4'b0000} +: 16];
      opb_d = op_b_i[{gnt_idx, 4'b0000} +: 16];
    end
    pipe_d = {pipe_q[MUL_LAT-1:0], pipe_t'{valid: xfer, tag: TAG_W'(gnt_idx)}};
  end

  mul16x16_signed u_mul (
    .clk_i (clk),
    .rst_i (~rst_n),
    .ce_i  (1'b1),
    .a_i   (opa_q),
    .b_i   (opb_q),
    .p_o   (mul_p)
  );

  always_comb begin
    p_d       = '0;
    p_valid_d = '0;
    if (pipe_q[MUL_LAT].valid) begin
      p_d = mul_p;
      for (int i = 0; i < int'(NREQ); i++) begin
        if (pipe_q[MUL_LAT].tag == TAG_W'(i)) p_valid_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i <= int'(MUL_LAT); i++) begin
      busy_o = busy_o | pipe_q[i].valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      skip_q     <= '0;
      lock_err_q <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      pipe_q     <= '0;
      p_q        <= '0;
      p_valid_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      skip_q     <= skip_d;
      lock_err_q <= lock_err_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      pipe_q     <= pipe_d;
      p_q        <= p_d;
      p_valid_q  <= p_valid_d;
    end
  end

  assign p_o        = p_q;
  assign p_valid_o  = p_valid_q;
  assign lock_err_o = lock_err_q;

endmodule

// File: tb/tb_mfcc_mul_arbiter.sv
// Directed bench for mfcc_mul_arbiter: single transfer, round-robin order,
// lock burst, lock watchdog and reset with products in flight.
module tb_mfcc_mul_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  lock;
  logic [47:0] op_a;
  logic [47:0] op_b;
  logic [2:0]  gnt;
  logic [31:0] p;
  logic [2:0]  p_valid;
  logic        busy;
  logic        lock_err;

  int checks = 0;
  int errors = 0;

  mfcc_mul_arbiter #(
    .NREQ     (3),
    .LOCK_MAX (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .lock_i     (lock),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .gnt_o      (gnt),
    .p_o        (p),
    .p_valid_o  (p_valid),
    .busy_o     (busy),
    .lock_err_o (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [2:0] onehot(input int r);
    case (r)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Hand-computed products for the round-robin operand set.
  function automatic logic [31:0] exp_prod(input int r);
    case (r)
      0:       return 32'hFFFF_FFFA;  // 3 * -2
      1:       return 32'h3FFF_0001;  // 32767 * 32767
      default: return 32'h4000_0000;  // -32768 * -32768
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  eg, ev;
    logic [31:0] ep;
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    op_a  = '0;
    op_b  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_pv", 32'(p_valid), 32'h0);
    chk("rst_p", p, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_lock_err", 32'(lock_err), 32'h0);
    rst_n = 1'b1;

    // Single requester: 0x0100 * 0xFF00 = -65536
    op_a = {16'h0000, 16'h0000, 16'h0100};
    op_b = {16'h0000, 16'h0000, 16'hFF00};
    req  = 3'b001;
    #1;
    chk("s_idle_gnt", 32'(gnt), 32'h0);
    tick();
    chk("s_gnt", 32'(gnt), 32'h1);
    tick();
    req = 3'b000;
    chk("s_busy", 32'(busy), 32'h1);
    chk("s_pv_early0", 32'(p_valid), 32'h0);
    repeat (3) tick();
    chk("s_pv_k3", 32'(p_valid), 32'h0);
    tick();
    chk("s_pv_k4", 32'(p_valid), 32'h1);
    chk("s_p_k4", p, 32'hFFFF_0000);
    tick();
    chk("s_pv_after", 32'(p_valid), 32'h0);
    chk("s_p_after", p, 32'h0);
    chk("s_busy_after", 32'(busy), 32'h0);

    // Round-robin, lock low
    do_reset();
    op_a = {16'h8000, 16'h7FFF, 16'h0003};
    op_b = {16'h8000, 16'h7FFF, 16'hFFFE};
    req  = 3'b111;
    tick();
    for (int m = 0; m < 12; m++) begin
      req = (m < 6) ? 3'b111 : 3'b000;
      #1;
      eg = (m < 6) ? onehot(m % 3) : 3'b000;
      ev = (m >= 5 && m < 11) ? onehot((m - 5) % 3) : 3'b000;
      ep = (m >= 5 && m < 11) ? exp_prod((m - 5) % 3) : 32'h0;
      chk($sformatf("rr_gnt%0d", m), 32'(gnt), 32'(eg));
      chk($sformatf("rr_pv%0d", m), 32'(p_valid), 32'(ev));
      chk($sformatf("rr_p%0d", m), p, ep);
      if (m == 2) chk("rr_busy", 32'(busy), 32'h1);
      tick();
    end

    // Lock burst on requester 1 while requester 0 also asks
    do_reset();
    req = 3'b001;
    tick();
    req  = 3'b011;
    lock = 3'b010;
    #1;
    chk("lk_pre_gnt", 32'(gnt), 32'h1);
    tick();
    for (int i = 0; i < 13; i++) begin
      #1;
      chk($sformatf("lk_gnt%0d", i), 32'(gnt), 32'h2);
      tick();
    end
    req  = 3'b001;
    lock = 3'b000;
    #1;
    chk("lk_gap_gnt", 32'(gnt), 32'h0);
    tick();
    chk("lk_next_gnt", 32'(gnt), 32'h1);
    chk("lk_no_err", 32'(lock_err), 32'h0);
    req = 3'b000;
    repeat (7) tick();
    chk("lk_drain_busy", 32'(busy), 32'h0);

    // Lock watchdog: 32 locked transfers then forced release
    do_reset();
    req  = 3'b100;
    lock = 3'b100;
    tick();
    #1;
    chk("wd_gnt1", 32'(gnt), 32'h4);
    tick();
    req = 3'b101;
    for (int i = 2; i <= 32; i++) begin
      #1;
      chk($sformatf("wd_gnt%0d", i), 32'(gnt), 32'h4);
      chk($sformatf("wd_err%0d", i), 32'(lock_err), 32'h0);
      tick();
    end
    #1;
    chk("wd_lock_err", 32'(lock_err), 32'h1);
    chk("wd_next_gnt", 32'(gnt), 32'h1);
    req  = 3'b000;
    lock = 3'b000;
    repeat (7) tick();
    chk("wd_busy_idle", 32'(busy), 32'h0);
    chk("wd_err_sticky", 32'(lock_err), 32'h1);
    chk("wd_pv_idle", 32'(p_valid), 32'h0);

    // Reset with products in flight
    do_reset();
    chk("mr_err_clr", 32'(lock_err), 32'h0);
    req = 3'b111;
    tick();
    repeat (5) tick();
    chk("mr_pv_before", 32'(p_valid), 32'h1);
    chk("mr_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mr_pv_rst", 32'(p_valid), 32'h0);
    chk("mr_p_rst", p, 32'h0);
    chk("mr_busy_rst", 32'(busy), 32'h0);
    chk("mr_gnt_rst", 32'(gnt), 32'h0);
    req = 3'b000;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("mr_pv_post%0d", i), 32'(p_valid), 32'h0);
      chk($sformatf("mr_busy_post%0d", i), 32'(busy), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
